// File: rtl/instr_seq.sv
// Instruction sequencer: loadable program memory plus PC that presents one
// registered instruction to the decoder and advances on its completion pulse.
module instr_seq #(
  parameter int DEPTH = 16,
  parameter bit WRAP  = 1'b0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [10:0]   load_data,
  input  logic [AW-1:0] last_addr,
  input  logic          run,
  input  logic          step,
  input  logic          halt_req,
  input  logic          instr_done,
  output logic [2:0]    opcode,
  output logic [3:0]    op1,
  output logic [3:0]    op2,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted,
  output logic          prog_end,
  output logic [7:0]    retired
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, nxt_pc;
  logic [10:0]   fields_q, fields_d;
  logic [7:0]    retired_q, retired_d;
  logic          prog_end_q, prog_end_d;
  logic          halt_pend_q, halt_pend_d;
  logic          step_mode_q, step_mode_d;
  logic          start, at_last;

  logic [10:0]   mem_q [DEPTH];

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (load_en && state_q != S_RUN) mem_q[load_addr] <= load_data;
  end

  assign start   = run | step;
  assign at_last = (pc_q == last_addr);
  assign nxt_pc  = (at_last && WRAP) ? '0 : pc_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fields_d    = fields_q;
    retired_d   = retired_q;
    prog_end_d  = prog_end_q;
    halt_pend_d = halt_pend_q;
    step_mode_d = step_mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          pc_d        = '0;
          fields_d    = mem_q[0];
          retired_d   = '0;
          prog_end_d  = 1'b0;
          halt_pend_d = 1'b0;
          step_mode_d = step & ~run;
        end
      end
      S_RUN: begin
        if (instr_done) begin
          retired_d = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
          pc_d      = nxt_pc;
          if (at_last && !WRAP) begin
            state_d     = S_HALT;
            prog_end_d  = 1'b1;
            halt_pend_d = 1'b0;
            step_mode_d = 1'b0;
          end else if (halt_pend_q || halt_req || step_mode_q) begin
            state_d     = S_HALT;
            halt_pend_d = 1'b0;
            step_mode_d = 1'b0;
          end else begin
            fields_d = mem_q[nxt_pc];
          end
        end else if (halt_req) begin
          halt_pend_d = 1'b1;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d     = S_RUN;
          halt_pend_d = 1'b0;
          step_mode_d = step & ~run;
          // After end-of-program a run restarts from the top instead of resuming.
          if (prog_end_q) begin
            pc_d       = '0;
            fields_d   = mem_q[0];
            retired_d  = '0;
            prog_end_d = 1'b0;
          end else begin
            fields_d = mem_q[pc_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      fields_q    <= '0;
      retired_q   <= '0;
      prog_end_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fields_q    <= fields_d;
      retired_q   <= retired_d;
      prog_end_q  <= prog_end_d;
      halt_pend_q <= halt_pend_d;
      step_mode_q <= step_mode_d;
    end
  end

  assign opcode   = fields_q[10:8];
  assign op1      = fields_q[7:4];
  assign op2      = fields_q[3:0];
  assign pc       = pc_q;
  assign running  = (state_q == S_RUN);
  assign halted   = (state_q == S_HALT);
  assign prog_end = prog_end_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_instr_seq.sv
// Bench for instr_seq: two instances (WRAP=0 and WRAP=1) share stimulus and are
// compared against a per-instance behavioural model plus directed constants.
module tb_instr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_en, run, step, halt_req, instr_done;
  logic [3:0]  load_addr, last_addr;
  logic [10:0] load_data;

  logic [1:0][2:0] opc;
  logic [1:0][3:0] o1, o2, pcv;
  logic [1:0]      runn, hlt, pend;
  logic [1:0][7:0] ret;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    instr_seq #(.DEPTH(16), .WRAP(g[0])) u_dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .last_addr(last_addr), .run(run), .step(step),
      .halt_req(halt_req), .instr_done(instr_done),
      .opcode(opc[g]), .op1(o1[g]), .op2(o2[g]), .pc(pcv[g]),
      .running(runn[g]), .halted(hlt[g]), .prog_end(pend[g]), .retired(ret[g])
    );
  end

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0=idle, 1=running, 2=halted.
  int          m_mode [2];
  int          m_pc   [2];
  int          m_ret  [2];
  bit          m_pe   [2];
  bit          m_hp   [2];
  bit          m_sm   [2];
  logic [10:0] m_fld  [2];
  logic [10:0] m_mem  [2][16];

  task automatic m_reset();
    for (int w = 0; w < 2; w++) begin
      m_mode[w] = 0; m_pc[w] = 0; m_ret[w] = 0;
      m_pe[w] = 0; m_hp[w] = 0; m_sm[w] = 0; m_fld[w] = '0;
    end
  endtask

  task automatic m_edge(input int w);
    int  mode0;
    int  nxt;
    bit  at_last;
    mode0 = m_mode[w];
    if (mode0 == 0) begin
      if (run || step) begin
        m_mode[w] = 1; m_pc[w] = 0; m_fld[w] = m_mem[w][0]; m_ret[w] = 0;
        m_pe[w] = 0; m_hp[w] = 0; m_sm[w] = step && !run;
      end
    end else if (mode0 == 1) begin
      if (instr_done) begin
        m_ret[w] = (m_ret[w] >= 255) ? 255 : m_ret[w] + 1;
        at_last  = (m_pc[w] == int'(last_addr));
        nxt      = (at_last && w == 1) ? 0 : (m_pc[w] + 1) % 16;
        m_pc[w]  = nxt;
        if (at_last && w == 0) begin
          m_mode[w] = 2; m_pe[w] = 1; m_hp[w] = 0; m_sm[w] = 0;
        end else if (m_hp[w] || halt_req || m_sm[w]) begin
          m_mode[w] = 2; m_hp[w] = 0; m_sm[w] = 0;
        end else begin
          m_fld[w] = m_mem[w][nxt];
        end
      end else if (halt_req) begin
        m_hp[w] = 1;
      end
    end else begin
      if (run || step) begin
        if (m_pe[w]) begin
          m_pc[w] = 0; m_ret[w] = 0; m_pe[w] = 0;
        end
        m_fld[w] = m_mem[w][m_pc[w]];
        m_mode[w] = 1; m_hp[w] = 0; m_sm[w] = step && !run;
      end
    end
    if (load_en && mode0 != 1) m_mem[w][load_addr] = load_data;
  endtask

  // Advance model and DUT by one edge, then drop all one-cycle strobes.
  task automatic tick();
    m_edge(0);
    m_edge(1);
    @(posedge clk);
    #1;
    run = 0; step = 0; halt_req = 0; instr_done = 0; load_en = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [10:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({opc[0], o1[0], o2[0], pcv[0], runn[0], hlt[0], pend[0], ret[0]} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
               {opc[0], o1[0], o2[0], pcv[0], runn[0], hlt[0], pend[0], ret[0]});
    end
    for (int a = 0; a < 16; a++) load_word(a[3:0], 11'($urandom));
  endtask

  task automatic test_program();
    load_word(4'd0, 11'h1A3);
    load_word(4'd1, 11'h2C5);
    load_word(4'd2, 11'h7F0);
    last_addr = 4'd2;
    run = 1; tick();
    checks++;
    if ({opc[0], o1[0], o2[0], runn[0]} !== {3'd1, 4'hA, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL run_first_fields: got op=%0d op1=%h op2=%h run=%b want 1 a 3 1",
               opc[0], o1[0], o2[0], runn[0]);
    end
    for (int i = 0; i < 3; i++) begin
      instr_done = 1; tick();
      tick();
    end
    checks++;
    if ({hlt[0], pend[0], pcv[0], ret[0]} !== {1'b1, 1'b1, 4'd3, 8'd3}) begin
      failures++;
      $display("FAIL prog_end: got halted=%b end=%b pc=%0d ret=%0d want 1 1 3 3",
               hlt[0], pend[0], pcv[0], ret[0]);
    end
  endtask

  task automatic test_halt_req();
    run = 1; tick();
    instr_done = 1; tick();
    halt_req = 1; tick();
    tick();
    instr_done = 1; tick();
    checks++;
    if ({hlt[0], pcv[0], pend[0]} !== {1'b1, 4'd2, 1'b0}) begin
      failures++;
      $display("FAIL halt_req: got halted=%b pc=%0d end=%b want 1 2 0", hlt[0], pcv[0], pend[0]);
    end
    run = 1; tick();
    checks++;
    if ({opc[0], o1[0], o2[0], runn[0], ret[0]} !== {3'd7, 4'hF, 4'd0, 1'b1, 8'd2}) begin
      failures++;
      $display("FAIL resume: got op=%0d op1=%h op2=%h run=%b ret=%0d want 7 f 0 1 2",
               opc[0], o1[0], o2[0], runn[0], ret[0]);
    end
    instr_done = 1; tick();
    checks++;
    if ({pend[0], ret[0]} !== {1'b1, 8'd3}) begin
      failures++;
      $display("FAIL resume_end: got end=%b ret=%0d want 1 3", pend[0], ret[0]);
    end
  endtask

  task automatic test_step();
    do_reset();
    step = 1; tick();
    checks++;
    if ({opc[0], o1[0], o2[0], runn[0]} !== {3'd1, 4'hA, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL step_fields: got op=%0d op1=%h op2=%h run=%b want 1 a 3 1",
               opc[0], o1[0], o2[0], runn[0]);
    end
    instr_done = 1; tick();
    checks++;
    if ({hlt[0], pcv[0], ret[0]} !== {1'b1, 4'd1, 8'd1}) begin
      failures++;
      $display("FAIL step_halt: got halted=%b pc=%0d ret=%0d want 1 1 1", hlt[0], pcv[0], ret[0]);
    end
    step = 1; tick();
    checks++;
    if ({opc[0], o1[0], o2[0], runn[0]} !== {3'd2, 4'hC, 4'd5, 1'b1}) begin
      failures++;
      $display("FAIL step2_fields: got op=%0d op1=%h op2=%h run=%b want 2 c 5 1",
               opc[0], o1[0], o2[0], runn[0]);
    end
    instr_done = 1; tick();
  endtask

  task automatic test_wrap();
    do_reset();
    last_addr = 4'd1;
    run = 1; tick();
    checks++;
    if (pcv[1] !== 4'd0) begin
      failures++;
      $display("FAIL wrap_pc0: got %0d want 0", pcv[1]);
    end
    for (int i = 0; i < 5; i++) begin
      instr_done = 1; tick();
      checks++;
      if ({pcv[1], runn[1], hlt[1]} !== {4'((i + 1) % 2), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL wrap_seq[%0d]: got pc=%0d run=%b halt=%b want %0d 1 0",
                 i, pcv[1], runn[1], hlt[1], (i + 1) % 2);
      end
    end
    checks++;
    if (ret[1] !== 8'd5) begin
      failures++;
      $display("FAIL wrap_retired: got %0d want 5", ret[1]);
    end
  endtask

  task automatic test_load_in_run();
    do_reset();
    last_addr = 4'd2;
    run = 1; tick();
    load_en = 1; load_addr = 4'd0; load_data = 11'h000; tick();
    for (int i = 0; i < 3; i++) begin
      instr_done = 1; tick();
    end
    run = 1; tick();
    checks++;
    if ({opc[0], o1[0], o2[0]} !== 11'h1A3) begin
      failures++;
      $display("FAIL load_ignored: got %h want 1a3", {opc[0], o1[0], o2[0]});
    end
    instr_done = 1; tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({opc[0], o1[0], o2[0], pcv[0], runn[0], hlt[0], pend[0], ret[0]} !== 28'd0) begin
      failures++;
      $display("FAIL async_reset: got %h want 0",
               {opc[0], o1[0], o2[0], pcv[0], runn[0], hlt[0], pend[0], ret[0]});
    end
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run = 1; tick();
    checks++;
    if ({opc[0], o1[0], o2[0], runn[0]} !== {11'h1A3, 1'b1}) begin
      failures++;
      $display("FAIL mem_after_reset: got %h run=%b want 1a3 1", {opc[0], o1[0], o2[0]}, runn[0]);
    end
  endtask

  task automatic test_random();
    logic [27:0] exp_v;
    for (int c = 0; c < 4000; c++) begin
      run        = ($urandom_range(0, 15) == 0);
      step       = ($urandom_range(0, 15) == 0);
      halt_req   = ($urandom_range(0, 11) == 0);
      instr_done = ($urandom_range(0, 2) == 0);
      load_en    = ($urandom_range(0, 7) == 0);
      load_addr  = 4'($urandom);
      load_data  = 11'($urandom);
      if ($urandom_range(0, 63) == 0) last_addr = 4'($urandom);
      tick();
      for (int w = 0; w < 2; w++) begin
        exp_v = {m_fld[w], 4'(m_pc[w]), m_mode[w] == 1, m_mode[w] == 2, m_pe[w], 8'(m_ret[w])};
        checks++;
        if ({opc[w], o1[w], o2[w], pcv[w], runn[w], hlt[w], pend[w], ret[w]} !== exp_v) begin
          failures++;
          $display("FAIL random[w%0d c%0d]: got %h want %h", w, c,
                   {opc[w], o1[w], o2[w], pcv[w], runn[w], hlt[w], pend[w], ret[w]}, exp_v);
        end
      end
    end
  endtask

  initial begin
    rst = 1; load_en = 0; load_addr = 0; load_data = 0; last_addr = 0;
    run = 0; step = 0; halt_req = 0; instr_done = 0;
    m_reset();
    test_reset();
    test_program();
    test_halt_req();
    test_step();
    test_wrap();
    test_load_in_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
